serial_pattern_detector: RTL
============================

Name: serial_pattern_detector

Overview:
Sequential stage that consumes the registered serial bit produced by the team's D flip-flop stage (its q output). It shifts the bit stream into a window, flags every occurrence of a fixed PATTERN_W-bit pattern, overlaps included, and keeps a saturating count of matches. Typical use is frame-sync or marker detection on a single-bit serial line in lab exercises.

Parameters:
PATTERN_W, 4, pattern length in bits (>= 2)
PATTERN, 4'b1011, pattern to detect; MSB is the oldest bit, LSB the newest
CNT_W, 8, width of match counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
en  input  1  shift enable; din is sampled only when high
clear  input  1  synchronous active-high clear of detector state and counter
din  input  1  serial data bit (from upstream d_ff q)
match  output  1  one-cycle pulse: the pattern completed at the last sampling edge
match_count  output  CNT_W  number of matches since reset/clear, saturating
sat  output  1  sticky flag: match_count reached all-ones

Behaviour:
- Priority at each rising clk edge: reset==0 > clear==1 > en==1 > hold.
- reset==0 at an edge: shreg (PATTERN_W-1 bits of history), fill counter, match, match_count and sat all go to 0. Reset takes effect mid-stream; no partial history survives it.
- clear==1 (with reset==1): same effect as reset. en and din are ignored that cycle.
- en==1:
  - window = {shreg, din}.
  - shreg <= window[PATTERN_W-2:0].
  - fill <= min(fill+1, PATTERN_W).
  - match <= (fill >= PATTERN_W-1) && (window == PATTERN).
- en==0: shreg and fill hold; match <= 0. A pattern may span en-low gaps, because only enabled samples count.
- Latency: match goes high right after the edge that samples the final pattern bit and stays high for exactly one clk period. It does not repeat unless a new enabled sample completes another match.
- Fill rule: no match until PATTERN_W bits have been sampled since reset/clear. Zero-initialised history must never create a false match (matters when PATTERN has leading zeros).
- Overlap: the history is kept after a match. For 1011, the stream 1011011 gives two matches.
- Counter: on the same edge that sets match, match_count <= match_count+1 if not all-ones, otherwise it holds.
  - sat <= 1 when match_count becomes all-ones.
  - sat clears only on reset or clear.
- Width rule: all comparisons are exactly PATTERN_W bits wide. No X may reach the outputs after the first reset edge.
- Outputs are registered; there is no combinational path from din, en, clear or reset to any output.

Test Plan:
1. Defaults; reset low for 2 edges, then en=1, din sequence 1,0,1,1,0,1,1 -> match pulses after the 4th and 7th samples, one cycle each; match_count=2; sat=0.
2. PATTERN=4'b0000; after reset, din=0 for 5 samples -> no match after samples 1-3; match after samples 4 and 5; match_count=2.
3. Defaults; din 1,0, then en=0 for 3 cycles with din=1, then en=1 with din 1,1 -> no match during the gap; match after the final sample; match_count=1.
4. CNT_W=2; feed the pattern 1011 five times back-to-back (non-overlapping, 20 samples) -> match_count goes 1,2,3,3,3; sat=1 from the third match onward; match still pulses each time.
5. Defaults; din 1,0,1 then reset=0 for one edge, then din 1 -> no match (history and fill cleared); all outputs 0 after the reset edge.
6. Defaults; clear=1 on the same edge that would complete 1011 (en=1) -> match stays 0, match_count=0; clear=1 together with reset=0 -> reset result, identical zeros.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts enabled din samples into a window, pulses match on
// every (overlapping) occurrence of PATTERN and keeps a saturating match count.
module serial_pattern_detector #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             sat
);

    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_MAX - 1'b1;

    logic [PATTERN_W-2:0] shreg;
    logic [FILL_W-1:0]    fill;
    logic [PATTERN_W-1:0] window;
    logic                 hit;

    // fill gates the compare so zeroed history never matches a pattern with leading zeros
    assign window = {shreg, din};
    assign hit    = (fill >= FILL_ARM) && (window == PATTERN);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            shreg       <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            sat         <= 1'b0;
        end else begin
            match <= 1'b0;
            if (en) begin
                shreg <= window[PATTERN_W-2:0];
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
                match <= hit;
                if (hit && (match_count != CNT_MAX)) begin
                    match_count <= match_count + 1'b1;
                    if (match_count == CNT_PRE) begin
                        sat <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
